dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer for the single-port data memory (32 x 32-bit words; write commits on posedge, read sampled on negedge).
- Master 0 is the core load/store path; master 1 is the debug/program-loader port.
- Serialises requests with round-robin fairness, rejects misaligned or out-of-range addresses without touching memory, and returns read data with a one-cycle ack.

Parameters:
- DATA_W, 32, data width of both masters and the memory.
- ADDR_W, 32, byte-address width.
- DEPTH_WORDS, 32, number of memory words; word index = addr >> 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- m0_req  in  1  master 0 request; held until m0_ack.
- m0_we  in  1  master 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  master 0 byte address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  valid with m0_ack; 1 = rejected.
- m0_rdata  out  DATA_W  read data, valid with m0_ack.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as m0_*, for master 1.
- mem_addr  out  ADDR_W  to memory Address.
- mem_wdata  out  DATA_W  to memory Write_data.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_rdata  in  DATA_W  from memory Read_data.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset (rst_n low at posedge):
  - State goes to IDLE, last_grant = 1 (master 0 wins the first tie).
  - All outputs are 0: acks, errs, rdata, mem_* .
- IDLE:
  - If no req, stay in IDLE.
  - Grant selection: if only one master requests, grant it. If both request, grant the master != last_grant, then update last_grant.
  - Latch sel, we, addr and wdata of the granted master.
  - Error when addr[1:0] != 0 or (addr >> 2) >= DEPTH_WORDS: go to RESP with err = 1. No memory cycle is issued.
  - Otherwise go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr = latched addr, mem_wdata = latched wdata.
  - mem_write = we, mem_read = !we.
  - The write commits at the posedge ending ACCESS. A read is sampled at the mid-cycle negedge, and arbiter rdata is captured from mem_rdata at that same posedge.
  - Then go to RESP.
- Outside ACCESS: mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0.
- RESP (one cycle):
  - m<sel>_ack = 1 and m<sel>_err as latched.
  - m<sel>_rdata = captured word for a successful read, 0 for writes and errors.
  - The non-selected master's outputs stay 0. Then go to IDLE.
- rdata holds its value until the next ack to that master.
- Latency: req sampled at edge k gives ack high in cycle k+2 (errors: cycle k+1). Throughput is 1 transaction per 3 cycles (per 2 for errors).
- Handshake:
  - A master holds req/we/addr/wdata stable until it sees ack.
  - req still high in the cycle after ack counts as a new request.
  - Req changes while not granted are permitted. Only the values sampled in IDLE matter.
- Fairness: with both masters continuously requesting, grants alternate 0,1,0,1…
- Simultaneous events: a new req arriving during ACCESS/RESP waits for IDLE. Unchanged req/addr changes in ACCESS are ignored because the transaction was latched.
- Reset mid-operation:
  - If rst_n is sampled low at the posedge ending ACCESS, a write still commits (mem_write was high), but no ack is issued. The master must reissue after reset.
  - Reset in RESP drops the ack.
- Word index uses the full address compare, so no wrap-around: addr 0x80 with DEPTH_WORDS = 32 is an error, not an alias of word 0.

Decomposition:
- Package dmem_arb_pkg: the state enum (IDLE/ACCESS/RESP) and constant master ids M0 = 0, M1 = 1.
- Sub-module rr_arb2: a two-input round-robin grant with a last_grant register, update enable and reset to 1.

Test Plan:
- Single access: m0 write 0x0000_0010 ← 0xDEADBEEF, then m0 read 0x10 → m0_ack at k+2 each time; read m0_rdata = 0xDEADBEEF, m0_err = 0; mem_write high for exactly one cycle.
- Contention: m0 and m1 both read continuously from reset → grant order m0, m1, m0, m1; ack pulses are 3 cycles apart; the idle master's ack is never high.
- Errors: m1 read 0x0000_0006 and m1 write 0x0000_0080 → m1_ack with m1_err = 1 one cycle after sampling; mem_read/mem_write stay 0; word 0 unchanged.
- Back-to-back: m0 holds req after ack with new addr 0x7C (last word) → a second transaction starts the next IDLE; write to 0x7C then read returns the written value.
- Reset mid-op: assert rst_n low at the edge ending an m1 write of 0x1234_5678 to 0x20 → no m1_ack; all outputs 0 next cycle; later read of 0x20 returns 0x1234_5678.
- Stability: change m0_addr during ACCESS → mem_addr holds the latched value; response corresponds to the originally sampled address.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg : shared state encoding and master ids for the data-memory arbiter
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2 : two-input round-robin grant; a tie goes to the master not granted last
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic       grant_valid,
  output logic       grant
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_valid  = |req;
    grant        = req[1] & (~req[0] | (last_grant_q == M0));
    last_grant_d = last_grant_q;
    if (update_en && grant_valid) begin
      last_grant_d = grant;
    end
  end

  // Resetting to M1 lets master 0 win the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= M1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter : two-master round-robin sequencer for the single-port data memory
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
  logic              m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

  logic              grant_valid;
  logic              grant;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_bad;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         ({m1_req, m0_req}),
    .update_en   (state_q == IDLE),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Full-width range compare so addresses past the array never alias low words.
  always_comb begin
    req_we    = (grant == M1) ? m1_we    : m0_we;
    req_addr  = (grant == M1) ? m1_addr  : m0_addr;
    req_wdata = (grant == M1) ? m1_wdata : m0_wdata;
    req_bad   = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= ADDR_W'(DEPTH_WORDS));
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    we_d        = we_q;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    m0_ack_d    = 1'b0;
    m0_err_d    = 1'b0;
    m1_ack_d    = 1'b0;
    m1_err_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          sel_d = grant;
          we_d  = req_we;
          if (req_bad) begin
            state_d = RESP;
            if (grant == M1) begin
              m1_ack_d   = 1'b1;
              m1_err_d   = 1'b1;
              m1_rdata_d = '0;
            end else begin
              m0_ack_d   = 1'b1;
              m0_err_d   = 1'b1;
              m0_rdata_d = '0;
            end
          end else begin
            state_d     = ACCESS;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
            mem_write_d = req_we;
            mem_read_d  = ~req_we;
          end
        end
      end
      ACCESS: begin
        // Read data was sampled by the memory at mid-cycle; capture it now.
        state_d = RESP;
        if (sel_q == M1) begin
          m1_ack_d   = 1'b1;
          m1_rdata_d = we_q ? '0 : mem_rdata;
        end else begin
          m0_ack_d   = 1'b1;
          m0_rdata_d = we_q ? '0 : mem_rdata;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= M0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      m0_ack_q    <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      m0_ack_q    <= m0_ack_d;
      m0_err_q    <= m0_err_d;
      m1_ack_q    <= m1_ack_d;
      m1_err_q    <= m1_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_ack    = m0_ack_q;
  assign m0_err    = m0_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_ack    = m1_ack_q;
  assign m1_err    = m1_err_q;
  assign m1_rdata  = m1_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter : directed and random traffic against a transaction-level model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_arbiter;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 32;
  localparam int DEPTH_WORDS = 32;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata = '0;

  logic [31:0] tbmem [DEPTH_WORDS] = '{default: '0};

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  // Single-port memory: write on posedge, read sampled on negedge, noise otherwise.
  always @(posedge clk) if (mem_write) tbmem[mem_addr[6:2]] <= mem_wdata;
  always @(negedge clk) mem_rdata <= mem_read ? tbmem[mem_addr[6:2]] : $urandom;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: schedules each granted transaction by its documented latency.
  int          e = 0;
  int          next_idle = 0;
  logic        last = 1'b1;
  int          ack_cyc [2] = '{-100, -100};
  logic        exp_err [2] = '{1'b0, 1'b0};
  logic [31:0] rd_next [2] = '{32'h0, 32'h0};
  logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};
  int          acc_cyc = -100;
  logic        acc_we = 1'b0;
  logic [31:0] acc_addr = '0, acc_wdata = '0;
  logic [31:0] ref_mem [DEPTH_WORDS] = '{default: '0};

  always @(posedge clk) begin : model
    logic        g, w;
    logic [31:0] a, wd;
    e = e + 1;
    if (!rst_n) begin
      ack_cyc   = '{-100, -100};
      exp_rdata = '{32'h0, 32'h0};
      acc_cyc   = -100;
      last      = 1'b1;
      next_idle = e + 1;
    end else if (e >= next_idle) begin
      if (m0_req || m1_req) begin
        g    = (m0_req && m1_req) ? ~last : m1_req;
        last = g;
        w    = g ? m1_we : m0_we;
        a    = g ? m1_addr : m0_addr;
        wd   = g ? m1_wdata : m0_wdata;
        if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH_WORDS) begin
          ack_cyc[g] = e;
          exp_err[g] = 1'b1;
          rd_next[g] = '0;
          next_idle  = e + 2;
        end else begin
          acc_cyc    = e;
          acc_we     = w;
          acc_addr   = a;
          acc_wdata  = wd;
          ack_cyc[g] = e + 1;
          exp_err[g] = 1'b0;
          rd_next[g] = w ? 32'h0 : ref_mem[a[6:2]];
          if (w) ref_mem[a[6:2]] = wd;
          next_idle  = e + 3;
        end
      end else begin
        next_idle = e + 1;
      end
    end
    for (int m = 0; m < 2; m++) if (ack_cyc[m] == e) exp_rdata[m] = rd_next[m];
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m0_ack",    32'(m0_ack),    32'(ack_cyc[0] == e));
      chk("m1_ack",    32'(m1_ack),    32'(ack_cyc[1] == e));
      chk("m0_err",    32'(m0_err),    32'(ack_cyc[0] == e && exp_err[0]));
      chk("m1_err",    32'(m1_err),    32'(ack_cyc[1] == e && exp_err[1]));
      chk("m0_rdata",  m0_rdata,       exp_rdata[0]);
      chk("m1_rdata",  m1_rdata,       exp_rdata[1]);
      chk("mem_write", 32'(mem_write), 32'(acc_cyc == e && acc_we));
      chk("mem_read",  32'(mem_read),  32'(acc_cyc == e && !acc_we));
      chk("mem_addr",  mem_addr,       (acc_cyc == e) ? acc_addr : 32'h0);
      chk("mem_wdata", mem_wdata,      (acc_cyc == e) ? acc_wdata : 32'h0);
    end
  end

  task automatic set_m(input int m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 1) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  // Issue one request (called #1 after an edge) and wait, bounded, for its ack.
  task automatic do_txn(input int m, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit keep,
                        output int lat, output logic [31:0] rd, output logic er);
    bit got;
    got = 1'b0;
    lat = 0;
    rd  = 'x;
    er  = 1'bx;
    set_m(m, 1'b1, we, addr, wdata);
    @(posedge clk);
    while (!got && lat < 30) begin
      @(negedge clk);
      lat++;
      if ((m == 1) ? m1_ack : m0_ack) begin
        got = 1'b1;
        rd  = (m == 1) ? m1_rdata : m0_rdata;
        er  = (m == 1) ? m1_err : m0_err;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) set_m(m, 1'b0, we, addr, wdata);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return {25'd0, 5'($urandom), 2'b00};
    else if (r == 7) return {25'd0, 5'($urandom), 2'($urandom_range(1, 3))};
    else if (r == 8) return 32'h80 + {$urandom_range(0, 63), 2'b00};
    else             return $urandom;
  endfunction

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          ack_m [$];
    int          ack_t [$];
    logic        s0, s1;

    rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_m0_ack", 32'(m0_ack), 32'd0);
    chk("rst_m1_ack", 32'(m1_ack), 32'd0);
    chk("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Contention from reset: both read continuously.
    set_m(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    for (int c = 0; c < 30 && ack_m.size() < 4; c++) begin
      @(negedge clk);
      if (m0_ack) begin ack_m.push_back(0); ack_t.push_back(c); end
      if (m1_ack) begin ack_m.push_back(1); ack_t.push_back(c); end
    end
    chk("rr_count", 32'(ack_m.size()), 32'd4);
    for (int i = 0; i < ack_m.size(); i++) begin
      chk("rr_order", 32'(ack_m[i]), 32'(i % 2));
      if (i > 0) chk("rr_spacing", 32'(ack_t[i] - ack_t[i-1]), 32'd3);
    end
    @(posedge clk);
    #1;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // Single write then read.
    do_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, lat, rd, er);
    chk("wr_lat", 32'(lat), 32'd2);
    chk("wr_err", 32'(er), 32'd0);
    do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 1'b0, lat, rd, er);
    chk("rd_lat", 32'(lat), 32'd2);
    chk("rd_data", rd, 32'hDEAD_BEEF);

    // Rejected accesses.
    do_txn(1, 1'b0, 32'h0000_0006, 32'h0, 1'b0, lat, rd, er);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'h0);
    do_txn(1, 1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 1'b0, lat, rd, er);
    chk("oor_lat", 32'(lat), 32'd1);
    chk("oor_err", 32'(er), 32'd1);
    do_txn(0, 1'b0, 32'h0000_0000, 32'h0, 1'b0, lat, rd, er);
    chk("word0_kept", rd, 32'h0);

    // Back-to-back on the last word with req held across the ack.
    do_txn(0, 1'b1, 32'h0000_007C, 32'hCAFE_F00D, 1'b1, lat, rd, er);
    do_txn(0, 1'b0, 32'h0000_007C, 32'h0, 1'b0, lat, rd, er);
    chk("b2b_lat", 32'(lat), 32'd2);
    chk("b2b_data", rd, 32'hCAFE_F00D);

    // Reset at the edge ending an m1 write.
    set_m(1, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_ack", 32'(m1_ack), 32'd0);
    chk("rst_mid_out", {29'd0, mem_write, mem_read, m0_ack}, 32'd0);
    chk("rst_mid_rdata", m0_rdata | m1_rdata, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_txn(1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, lat, rd, er);
    chk("rst_mid_commit", rd, 32'h1234_5678);

    // Address changes during ACCESS are ignored.
    set_m(0, 1'b1, 1'b1, 32'h0000_0014, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    m0_addr  = 32'h0000_0018;
    m0_wdata = 32'h1111_1111;
    @(negedge clk);
    chk("stab_addr", mem_addr, 32'h0000_0014);
    chk("stab_wdata", mem_wdata, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("stab_ack", 32'(m0_ack), 32'd1);
    @(posedge clk);
    #1 set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_txn(0, 1'b0, 32'h0000_0014, 32'h0, 1'b0, lat, rd, er);
    chk("stab_rd14", rd, 32'hA5A5_A5A5);
    do_txn(0, 1'b0, 32'h0000_0018, 32'h0, 1'b0, lat, rd, er);
    chk("stab_rd18", rd, 32'h0);

    // Random traffic: each master holds its request until acked.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      s0 = m0_ack;
      s1 = m1_ack;
      @(posedge clk);
      #1;
      if (m0_req && s0) begin
        if ($urandom_range(0, 1) == 1) set_m(0, 1'b1, 1'($urandom), rand_addr(), $urandom);
        else m0_req = 1'b0;
      end else if (!m0_req && $urandom_range(0, 2) == 0) begin
        set_m(0, 1'b1, 1'($urandom), rand_addr(), $urandom);
      end
      if (m1_req && s1) begin
        if ($urandom_range(0, 1) == 1) set_m(1, 1'b1, 1'($urandom), rand_addr(), $urandom);
        else m1_req = 1'b0;
      end else if (!m1_req && $urandom_range(0, 2) == 0) begin
        set_m(1, 1'b1, 1'($urandom), rand_addr(), $urandom);
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (6) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
